// File: rtl/ssg_pkg.sv
// Shared types and default constants for the secure strobe generator.
//   ssg_state_e           : sequencer state encoding
//   SSG_STATUS_DLY_DEF    : default rst1-rise to status-fall delay (cycles)
//   SSG_STROBE_DLY_DEF    : default status-fall to strobe delay (cycles)
//   SSG_KEY_DEF           : default payload driven on data
package ssg_pkg;

  localparam int unsigned SSG_DATA_W         = 32;
  localparam int unsigned SSG_STATUS_DLY_DEF = 9;
  localparam int unsigned SSG_STROBE_DLY_DEF = 5;
  localparam logic [SSG_DATA_W-1:0] SSG_KEY_DEF = 32'h0000_00FF;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_STATUS = 3'd1,
    S_WAIT_STROBE = 3'd2,
    S_FIRE        = 3'd3,
    S_DONE        = 3'd4
  } ssg_state_e;

  // Larger of two delays, used to size the shared delay counter.
  function automatic int unsigned ssg_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ssg_dly_cnt.sv
// Loadable saturating down-counter used to time the status and strobe delays.
//   clk        : clock, rising edge
//   rst2       : asynchronous active-low reset, clears the count
//   i_load     : load i_load_val this cycle (takes priority over counting)
//   i_load_val : value to load
//   o_zero     : count is zero
// The counter decrements every cycle while non-zero and sticks at zero.
module ssg_dly_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst2,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  // Count register: load wins, otherwise count down to zero and hold.
  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (r_value != '0) begin
      r_value <= r_value - W'(1);
    end
  end

  assign o_zero = (r_value == '0);

endmodule

// File: rtl/secure_strobe_gen.sv
// Secure strobe generator: after a rising edge of the soft reset rst1, drops
// status after STATUS_DLY cycles, then fires a one-cycle strobe STROBE_DLY
// cycles later. data carries KEY; in secure mode it is withheld until the
// strobe cycle.
//   clk        : clock, rising edge
//   rst2       : asynchronous active-low reset, clears everything incl. data
//   rst1       : synchronous active-low soft reset, restarts sequence, holds data
//   secure_in  : secure-mode request, captured on the rst1 rise edge
//   secure_out : captured secure mode, gated by rst1
//   status     : busy/not-ready, high while idle or counting to status fall
//   strobe     : single-cycle data-valid pulse
//   data       : payload
// Build option: define SSG_REARM_EN to re-run the status/strobe sequence
// continuously while rst1 stays high; otherwise the sequence ends in DONE.
module secure_strobe_gen
  import ssg_pkg::*;
#(
  parameter int unsigned STATUS_DLY = SSG_STATUS_DLY_DEF,
  parameter int unsigned STROBE_DLY = SSG_STROBE_DLY_DEF,
  parameter logic [SSG_DATA_W-1:0] KEY = SSG_KEY_DEF
) (
  input  logic                  clk,
  input  logic                  rst2,
  input  logic                  rst1,
  input  logic                  secure_in,
  output logic                  secure_out,
  output logic                  status,
  output logic                  strobe,
  output logic [SSG_DATA_W-1:0] data
);

  localparam int unsigned CNT_W = $clog2(ssg_max(STATUS_DLY, STROBE_DLY)) + 1;

  // Delay parameters below these minimums break the cycle accounting.
  if (STATUS_DLY < 2) begin : g_bad_status_dly
    $error("secure_strobe_gen: STATUS_DLY must be >= 2");
  end
  if (STROBE_DLY < 1) begin : g_bad_strobe_dly
    $error("secure_strobe_gen: STROBE_DLY must be >= 1");
  end

  ssg_state_e            r_state;
  ssg_state_e            w_state_nxt;
  logic                  r_rst1_q;
  logic                  r_secure_q;
  logic                  r_status_q;
  logic                  r_strobe_q;
  logic [SSG_DATA_W-1:0] r_data;

  logic                  w_secure_nxt;
  logic                  w_status_nxt;
  logic                  w_strobe_nxt;
  logic [SSG_DATA_W-1:0] w_data_nxt;
  logic                  w_rise;
  logic                  w_load;
  logic [CNT_W-1:0]      w_load_val;
  logic                  w_zero;

  assign w_rise = rst1 & ~r_rst1_q;

  // Counter is loaded with DLY-1 so it reads zero on the cycle before the
  // transition edge; the transition itself consumes the last cycle.
  ssg_dly_cnt #(
    .W (CNT_W)
  ) u_dly_cnt (
    .clk        (clk),
    .rst2       (rst2),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_state    <= S_IDLE;
      r_rst1_q   <= 1'b0;
      r_secure_q <= 1'b0;
      r_status_q <= 1'b1;
      r_strobe_q <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst1_q   <= rst1;
      r_secure_q <= w_secure_nxt;
      r_status_q <= w_status_nxt;
      r_strobe_q <= w_strobe_nxt;
      r_data     <= w_data_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_secure_nxt = r_secure_q;
    w_status_nxt = r_status_q;
    w_strobe_nxt = 1'b0;
    w_data_nxt   = r_data;
    w_load       = 1'b0;
    w_load_val   = '0;

    if (!rst1) begin
      // Soft reset: abort sequence, keep data frozen.
      w_state_nxt  = S_IDLE;
      w_secure_nxt = 1'b0;
      w_status_nxt = 1'b1;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_status_nxt = 1'b1;
          if (w_rise) begin
            w_state_nxt  = S_WAIT_STATUS;
            w_secure_nxt = secure_in;
            w_load       = 1'b1;
            w_load_val   = CNT_W'(STATUS_DLY - 1);
          end
        end
        S_WAIT_STATUS: begin
          w_status_nxt = 1'b1;
          if (w_zero) begin
            w_state_nxt  = S_WAIT_STROBE;
            w_status_nxt = 1'b0;
            w_load       = 1'b1;
            w_load_val   = CNT_W'(STROBE_DLY - 1);
            if (!r_secure_q) begin
              w_data_nxt = KEY;
            end
          end
        end
        S_WAIT_STROBE: begin
          if (w_zero) begin
            w_state_nxt  = S_FIRE;
            w_strobe_nxt = 1'b1;
            w_data_nxt   = KEY;
          end
        end
        S_FIRE: begin
`ifdef SSG_REARM_EN
          // FIRE already used one cycle of the next status delay.
          w_state_nxt  = S_WAIT_STATUS;
          w_status_nxt = 1'b1;
          w_load       = 1'b1;
          w_load_val   = CNT_W'(STATUS_DLY - 2);
`else
          w_state_nxt  = S_DONE;
`endif
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_status_nxt = 1'b1;
        end
      endcase
    end
  end

  // rst1 gating is combinational so a soft reset shows in the same cycle.
  assign secure_out = r_secure_q & rst1;
  assign status     = r_status_q | ~rst1;
  assign strobe     = r_strobe_q & rst1;
  assign data       = r_data;

endmodule
